if_fetch_unit: RTL and testbench

//  Instruction fetch port directly downstream of the PC generator. Takes each fetch PC,

---
 rtl/if_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
//   Instruction fetch port that sits directly after the PC generator. It accepts
//   one fetch PC at a time and issues one doubleword-aligned read for it. It then
//   selects the 32-bit word that the PC addresses and queues {pc, inst} in a small
//   FIFO. The decode stage drains that FIFO with valid/ready.
//
//   Only one memory transaction is outstanding at a time. A flush empties the FIFO.
//   It also cancels an ungranted request. If the request was already granted, the
//   response is still waited for and then discarded.
//
// Optional feature macro: IF_FETCH_MISALIGN_CHK_EN
//   When it is defined, a PC with pc[1:0]!=0 is not fetched. Instead a NOP
//   (32'h0000_0013) is queued with inst_misalign_o=1 on the following edge.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pc_i/pc_valid_i/pc_ready_o   fetch PC handshake
//   flush_i                  discard queued and in-flight fetches
//   mem_req_o/mem_addr_o/mem_gnt_i          read request (held until granted)
//   mem_rvalid_i/mem_rdata_i                read response (64-bit, little-endian)
//   inst_valid_o/inst_ready_i/inst_o/inst_pc_o   decode-side queue head
//   inst_misalign_o          (macro only) head entry was a misaligned PC
module if_fetch_unit #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [63:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o
`ifdef IF_FETCH_MISALIGN_CHK_EN
  ,
  output logic        inst_misalign_o
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, MIS} state_t;

  state_t          state, state_nxt;
  logic [63:0]     pc_q;
  logic [CW-1:0]   count;
  logic [PW-1:0]   head, tail;
  logic [63:0]     q_pc   [FIFO_DEPTH];
  logic [31:0]     q_inst [FIFO_DEPTH];

  logic            accept, push, pop, mis_acc;
  logic [31:0]     push_inst;

  // The space check is made at accept. Only one fetch can be in flight, so a
  // push never finds the FIFO full.
  assign pc_ready_o = !rst && (state == IDLE) && !flush_i && (count < CW'(FIFO_DEPTH));
  assign accept     = pc_ready_o && pc_valid_i;
  assign pop        = inst_valid_o && inst_ready_i && !flush_i;

`ifdef IF_FETCH_MISALIGN_CHK_EN
  logic q_mis [FIFO_DEPTH];
  logic push_mis;
  assign mis_acc = (pc_i[1:0] != 2'b00);
`else
  assign mis_acc = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_inst = pc_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
`ifdef IF_FETCH_MISALIGN_CHK_EN
    push_mis  = 1'b0;
`endif
    case (state)
      IDLE:  if (accept) state_nxt = mis_acc ? MIS : REQ;
      REQ: begin
        // A granted request cannot be withdrawn, so a flush together with a
        // grant still has to absorb the response.
        if (mem_gnt_i)    state_nxt = flush_i ? DRAIN : WAIT;
        else if (flush_i) state_nxt = IDLE;
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          push      = !flush_i;
          state_nxt = IDLE;
        end else if (flush_i) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: if (mem_rvalid_i) state_nxt = IDLE;
`ifdef IF_FETCH_MISALIGN_CHK_EN
      MIS: begin
        push      = !flush_i;
        push_inst = 32'h0000_0013;
        push_mis  = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc_q  <= '0;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) pc_q <= pc_i;
      if (flush_i) begin
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        // FIFO_DEPTH is a power of two, so the pointers wrap naturally.
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // The storage needs no reset. The outputs are masked with inst_valid_o.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]   <= pc_q;
      q_inst[tail] <= push_inst;
`ifdef IF_FETCH_MISALIGN_CHK_EN
      q_mis[tail]  <= push_mis;
`endif
    end
  end

  assign mem_req_o    = (state == REQ);
  assign mem_addr_o   = {pc_q[63:3], 3'b000};
  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? q_inst[head] : 32'h0;
  assign inst_pc_o    = inst_valid_o ? q_pc[head]   : 64'h0;
`ifdef IF_FETCH_MISALIGN_CHK_EN
  assign inst_misalign_o = inst_valid_o ? q_mis[head] : 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit. It runs directed scenarios with literal
// expectations, then a randomized phase. A behavioural model (queue of pending
// instructions plus an "outstanding fetch" record) is checked every cycle.
module tb_if_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_i;
  logic        pc_valid_i, pc_ready_o, flush_i;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic [63:0] mem_addr_o, mem_rdata_i;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
`ifdef IF_FETCH_MISALIGN_CHK_EN
  logic        inst_misalign_o;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_ready_i(inst_ready_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o)
`ifdef IF_FETCH_MISALIGN_CHK_EN
    , .inst_misalign_o(inst_misalign_o)
`endif
  );

  typedef struct { logic [63:0] pc; logic [31:0] inst; logic mis; } ent_t;

  // Model state: instructions decode should see, and the one fetch in flight.
  ent_t        q[$];
  bit          m_busy, m_gnt, m_drop, m_mis;
  logic [63:0] m_pc = '0;
  int          errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return (rst == 1'b0) && !flush_i && !m_busy && (q.size() < DEPTH);
  endfunction

  function automatic bit exp_req();
    return m_busy && !m_gnt && !m_mis;
  endfunction

  always @(posedge clk) begin
    bit acc;
    ent_t e;
    acc = exp_ready() && pc_valid_i;
    if (rst) begin
      q.delete();
      m_busy = 0; m_gnt = 0; m_drop = 0; m_mis = 0; m_pc = '0;
    end else begin
      if (flush_i) q.delete();
      else if (q.size() > 0 && inst_ready_i) void'(q.pop_front());
      if (m_mis) begin
        if (!flush_i) begin e.pc = m_pc; e.inst = 32'h13; e.mis = 1; q.push_back(e); end
        m_busy = 0; m_mis = 0;
      end else if (m_busy && !m_gnt) begin
        if (mem_gnt_i) begin m_gnt = 1; m_drop = flush_i; end
        else if (flush_i) m_busy = 0;
      end else if (m_busy) begin
        if (mem_rvalid_i) begin
          if (!m_drop && !flush_i) begin
            e.pc = m_pc; e.mis = 0;
            e.inst = m_pc[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
            q.push_back(e);
          end
          m_busy = 0; m_gnt = 0; m_drop = 0;
        end else if (flush_i) m_drop = 1;
      end
      if (acc) begin
        m_busy = 1; m_pc = pc_i;
`ifdef IF_FETCH_MISALIGN_CHK_EN
        m_mis = (pc_i[1:0] != 2'b00);
`endif
      end
    end
  end

  always @(negedge clk) begin
    chk("pc_ready", pc_ready_o, exp_ready());
    chk("mem_req", mem_req_o, exp_req());
    if (exp_req()) chk("mem_addr", mem_addr_o, {m_pc[63:3], 3'b000});
    chk("inst_valid", inst_valid_o, q.size() != 0);
    if (q.size() != 0) begin
      chk("inst", inst_o, q[0].inst);
      chk("inst_pc", inst_pc_o, q[0].pc);
`ifdef IF_FETCH_MISALIGN_CHK_EN
      chk("inst_misalign", inst_misalign_o, q[0].mis);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Accept at the first edge, grant in the next cycle, and return data one cycle
  // later. The task returns at the start of the cycle in which the entry is visible.
  task automatic fetch(input logic [63:0] pc, input logic [63:0] data, input bit pop_rv);
    pc_valid_i = 1; pc_i = pc; cyc();
    pc_valid_i = 0; mem_gnt_i = 1; cyc();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = data; inst_ready_i = pop_rv; cyc();
    mem_rvalid_i = 0; inst_ready_i = 0;
  endtask

  initial begin : main
    bit pend;
    int dly;
    rst = 1; pc_i = 0; pc_valid_i = 0; flush_i = 0; mem_gnt_i = 0;
    mem_rvalid_i = 0; mem_rdata_i = 0; inst_ready_i = 0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_pc_ready", pc_ready_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_inst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_inst_pc", inst_pc_o, 0);
    cyc();
    rst = 0;

    // 1: aligned low word, data visible three cycles after accept
    pc_valid_i = 1; pc_i = 64'h8000_0000;
    @(negedge clk); chk("t1_ready", pc_ready_o, 1); cyc();
    pc_valid_i = 0; mem_gnt_i = 1;
    @(negedge clk); chk("t1_req", mem_req_o, 1); chk("t1_addr", mem_addr_o, 64'h8000_0000); cyc();
    mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'h0010_0093_0000_0513;
    @(negedge clk); chk("t1_valid_early", inst_valid_o, 0); cyc();
    mem_rvalid_i = 0;
    @(negedge clk);
    chk("t1_valid", inst_valid_o, 1); chk("t1_inst", inst_o, 32'h0000_0513);
    chk("t1_pc", inst_pc_o, 64'h8000_0000);
    cyc();

    // 2: upper word, FIFO fills, head held, pop frees a slot
    fetch(64'h8000_0004, 64'h0010_0093_0000_0513, 0);
    pc_valid_i = 1; pc_i = 64'h8000_0008;
    @(negedge clk);
    chk("t2_full_ready", pc_ready_o, 0); chk("t2_hold_inst", inst_o, 32'h0000_0513);
    cyc();
    @(negedge clk); chk("t2_hold_pc", inst_pc_o, 64'h8000_0000); cyc();
    pc_valid_i = 0; inst_ready_i = 1; cyc();
    inst_ready_i = 0;
    @(negedge clk);
    chk("t2_ready_back", pc_ready_o, 1); chk("t2_inst2", inst_o, 32'h0010_0093);
    chk("t2_pc2", inst_pc_o, 64'h8000_0004);
    inst_ready_i = 1; cyc(); inst_ready_i = 0;

    // 3: grant withheld, then flush while waiting for data
    pc_valid_i = 1; pc_i = 64'h8000_0010; cyc();
    pc_valid_i = 0;
    repeat (5) begin
      @(negedge clk); chk("t3_req", mem_req_o, 1); chk("t3_addr", mem_addr_o, 64'h8000_0010); cyc();
    end
    mem_gnt_i = 1; cyc();
    mem_gnt_i = 0; flush_i = 1; cyc();
    flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 64'hdead_beef_cafe_f00d;
    @(negedge clk); chk("t3_drain_ready", pc_ready_o, 0); cyc();
    mem_rvalid_i = 0;
    @(negedge clk); chk("t3_ready", pc_ready_o, 1); chk("t3_valid", inst_valid_o, 0);

    // 4: each push coincides with a pop once one entry is queued
    for (int i = 0; i < 8; i++)
      fetch(64'h1000 + 64'(4 * i), {32'h100 + 32'(i), 32'h200 + 32'(i)}, 1);
    @(negedge clk);
    chk("t4_valid", inst_valid_o, 1); chk("t4_pc", inst_pc_o, 64'h101C);
    chk("t4_inst", inst_o, 32'h107);
    inst_ready_i = 1; cyc(); inst_ready_i = 0;

    // 5: reset while waiting for data, then a stray response
    pc_valid_i = 1; pc_i = 64'h2000; cyc();
    pc_valid_i = 0; mem_gnt_i = 1; cyc();
    mem_gnt_i = 0; rst = 1; cyc();
    rst = 0; mem_rvalid_i = 1; mem_rdata_i = 64'h1111_2222_3333_4444; cyc();
    mem_rvalid_i = 0;
    @(negedge clk);
    chk("t5_valid", inst_valid_o, 0); chk("t5_req", mem_req_o, 0);
    chk("t5_addr", mem_addr_o, 0); chk("t5_inst", inst_o, 0); chk("t5_ready", pc_ready_o, 1);
    cyc();
    fetch(64'h3004, 64'hAAAA_BBBB_CCCC_DDDD, 0);
    @(negedge clk); chk("t5_next_inst", inst_o, 32'hAAAA_BBBB); chk("t5_next_pc", inst_pc_o, 64'h3004);
    inst_ready_i = 1; cyc(); inst_ready_i = 0;

`ifdef IF_FETCH_MISALIGN_CHK_EN
    // 6: misaligned PC becomes a flagged NOP without touching memory
    pc_valid_i = 1; pc_i = 64'h8000_0002; cyc();
    pc_valid_i = 0;
    @(negedge clk); chk("t6_req", mem_req_o, 0); cyc();
    @(negedge clk);
    chk("t6_inst", inst_o, 32'h13); chk("t6_mis", inst_misalign_o, 1);
    chk("t6_pc", inst_pc_o, 64'h8000_0002);
    inst_ready_i = 1; cyc(); inst_ready_i = 0;
`endif

    // Random phase. The memory responder grants at random and returns data 1-4
    // cycles after the grant. It also drives occasional stray responses.
    pend = 0; dly = 0;
    for (int n = 0; n < 4000; n++) begin
      if (rst) pend = 0;
      else begin
        if (mem_rvalid_i) pend = 0;
        if (mem_gnt_i) begin pend = 1; dly = $urandom_range(0, 3); end
      end
      rst          = ($urandom_range(0, 299) == 0);
      flush_i      = ($urandom_range(0, 15) == 0);
      pc_valid_i   = ($urandom_range(0, 9) < 7);
      pc_i         = {$urandom, $urandom};
`ifdef IF_FETCH_MISALIGN_CHK_EN
      if ($urandom_range(0, 3) != 0) pc_i[1:0] = 2'b00;
`endif
      inst_ready_i = ($urandom_range(0, 9) < 5);
      mem_gnt_i    = mem_req_o && ($urandom_range(0, 1) == 1);
      mem_rvalid_i = pend ? (dly == 0) : ($urandom_range(0, 19) == 0);
      if (pend && dly > 0) dly--;
      mem_rdata_i  = {$urandom, $urandom};
      cyc();
    end

    rst = 0; flush_i = 0; pc_valid_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; inst_ready_i = 0;
    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
